// File: rtl/out_fifo_if.sv
// Fabric-to-PHY handshake bundle for the transmit-side FIFO: lane write data in,
// nibble/byte read data and occupancy flags out.
interface out_fifo_if;
  logic       WREN;
  logic       RDEN;
  logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7, D8, D9;
  logic [3:0] Q0, Q1, Q2, Q3, Q4, Q7, Q8, Q9;
  logic [7:0] Q5, Q6;
  logic       EMPTY;
  logic       ALMOSTEMPTY;
  logic       FULL;
  logic       ALMOSTFULL;

  modport master (
    output WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
    input  EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL
  );

  modport slave (
    input  WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
    output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
    output EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL
  );
endinterface

// File: rtl/out_fifo_sync.sv
// Single-clock 8-entry x 80-bit transmit FIFO: byte lanes written per entry,
// drained as nibbles (two per entry in 8_X_4 mode) with lanes 5/6 passed as bytes.
module out_fifo_sync #(
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter     ARRAY_MODE         = "ARRAY_MODE_8_X_4"
) (
  input logic CLK,
  input logic RESET,
  out_fifo_if.slave bus
);

  localparam bit MODE_4X4 = (ARRAY_MODE == "ARRAY_MODE_4_X_4");
  localparam bit MODE_OK  = MODE_4X4 || (ARRAY_MODE == "ARRAY_MODE_8_X_4");
  localparam logic [3:0] AE_THR = 4'(ALMOST_EMPTY_VALUE);
  localparam logic [3:0] AF_THR = 4'(ALMOST_FULL_VALUE);

  if (!MODE_OK || ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2 ||
      ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : g_bad_param
    $fatal(0, "Syntax error in instance %m: illegal out_fifo_sync parameter value");
  end

  typedef logic [9:0][7:0] entry_t;

  // Nibble-output slot j drives lane j for j<5 and lane j+2 otherwise (lanes 5/6 are bytes).
  function automatic int lane_of(input int slot);
    return (slot < 5) ? slot : slot + 2;
  endfunction

  entry_t          r_mem [0:7];
  logic [2:0]      r_wptr;
  logic [2:0]      r_rptr;
  logic [3:0]      r_count;
  logic            r_hp;
  logic [7:0][3:0] r_qn;
  logic [7:0]      r_q5;
  logic [7:0]      r_q6;

  entry_t          w_din;
  entry_t          w_entry;
  logic            w_empty;
  logic            w_full;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic            w_rd_done;
  logic            w_sel_hi;
  logic [7:0][3:0] w_qn_next;

  assign w_din = {bus.D9, bus.D8, bus.D7, bus.D6, bus.D5,
                  bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};

  assign w_empty   = (r_count == 4'd0);
  assign w_full    = (r_count == 4'd8);
  assign w_wr_ok   = bus.WREN && !w_full;
  assign w_rd_ok   = bus.RDEN && !w_empty;
  // An entry is retired only on its last read: immediately in 4_X_4, on the high half otherwise.
  assign w_rd_done = w_rd_ok && (MODE_4X4 || r_hp);
  assign w_sel_hi  = !MODE_4X4 && r_hp;
  assign w_entry   = r_mem[r_rptr];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_qn_next = '0;
    for (int j = 0; j < 8; j++) begin
      w_qn_next[j] = w_sel_hi ? w_entry[lane_of(j)][7:4] : w_entry[lane_of(j)][3:0];
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= w_din;
    end
  end

  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hp    <= 1'b0;
      r_qn    <= '0;
      r_q5    <= '0;
      r_q6    <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 3'd1;
      end
      if (w_rd_done) begin
        r_rptr <= r_rptr + 3'd1;
      end
      if (w_rd_ok) begin
        r_hp <= !MODE_4X4 && !r_hp;
        r_qn <= w_qn_next;
        r_q5 <= w_entry[5];
        r_q6 <= w_entry[6];
      end
      r_count <= r_count + {3'b000, w_wr_ok} - {3'b000, w_rd_done};
    end
  end

  assign bus.Q0 = r_qn[0];
  assign bus.Q1 = r_qn[1];
  assign bus.Q2 = r_qn[2];
  assign bus.Q3 = r_qn[3];
  assign bus.Q4 = r_qn[4];
  assign bus.Q7 = r_qn[5];
  assign bus.Q8 = r_qn[6];
  assign bus.Q9 = r_qn[7];
  assign bus.Q5 = r_q5;
  assign bus.Q6 = r_q6;

  assign bus.EMPTY       = w_empty;
  assign bus.FULL        = w_full;
  assign bus.ALMOSTEMPTY = (r_count <= AE_THR);
  assign bus.ALMOSTFULL  = ((4'd8 - r_count) <= AF_THR);

endmodule

// File: tb/tb_out_fifo_sync.sv
// Drives an 8_X_4 instance and a 4_X_4 instance with identical stimulus and
// compares both against a queue-based reference model.
module tb_out_fifo_sync;

  typedef logic [79:0] entry_t;

  logic   CLK = 1'b0;
  logic   RESET;
  logic   wren;
  logic   rden;
  entry_t din;

  always #5 CLK = ~CLK;

  out_fifo_if bus [2] ();

  logic [47:0] q_obs    [2];
  logic [3:0]  flag_obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].WREN = wren;
    assign bus[g].RDEN = rden;
    assign bus[g].D0 = din[7:0];
    assign bus[g].D1 = din[15:8];
    assign bus[g].D2 = din[23:16];
    assign bus[g].D3 = din[31:24];
    assign bus[g].D4 = din[39:32];
    assign bus[g].D5 = din[47:40];
    assign bus[g].D6 = din[55:48];
    assign bus[g].D7 = din[63:56];
    assign bus[g].D8 = din[71:64];
    assign bus[g].D9 = din[79:72];
    assign q_obs[g] = {bus[g].Q9, bus[g].Q8, bus[g].Q7, bus[g].Q6, bus[g].Q5,
                       bus[g].Q4, bus[g].Q3, bus[g].Q2, bus[g].Q1, bus[g].Q0};
    assign flag_obs[g] = {bus[g].EMPTY, bus[g].ALMOSTEMPTY, bus[g].FULL, bus[g].ALMOSTFULL};

    out_fifo_sync #(
      .ALMOST_EMPTY_VALUE(g == 0 ? 1 : 2),
      .ALMOST_FULL_VALUE (g == 0 ? 1 : 2),
      .ARRAY_MODE        (g == 0 ? "ARRAY_MODE_8_X_4" : "ARRAY_MODE_4_X_4")
    ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus[g].slave)
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of whole entries per instance plus the half-read bit.
  entry_t      mq0 [$];
  entry_t      mq1 [$];
  logic        m_hp [2];
  logic [47:0] m_q  [2];

  function automatic int ae_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int af_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic model_edge(input int k);
    entry_t      q [$];
    entry_t      e;
    logic [47:0] qn;
    logic [7:0]  b;
    int          pos;
    bit          mode4 = (k == 1);
    bit          wr, rd;
    if (k == 0) q = mq0; else q = mq1;
    if (RESET) begin
      q.delete();
      m_hp[k] = 1'b0;
      m_q[k]  = '0;
    end else begin
      wr = wren && (q.size() < 8);
      rd = rden && (q.size() > 0);
      if (rd) begin
        e   = q[0];
        qn  = '0;
        pos = 0;
        for (int lane = 0; lane < 10; lane++) begin
          b = e[8*lane +: 8];
          if (lane == 5 || lane == 6) begin
            qn[pos +: 8] = b;
            pos += 8;
          end else begin
            qn[pos +: 4] = (!mode4 && m_hp[k]) ? b[7:4] : b[3:0];
            pos += 4;
          end
        end
        m_q[k] = qn;
        if (mode4 || m_hp[k]) begin
          void'(q.pop_front());
          m_hp[k] = 1'b0;
        end else begin
          m_hp[k] = 1'b1;
        end
      end
      if (wr) q.push_back(din);
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic check_all();
    int n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? mq0.size() : mq1.size();
      check($sformatf("q%0d", k), 64'(q_obs[k]), 64'(m_q[k]));
      check($sformatf("empty%0d", k), 64'(flag_obs[k][3]), 64'(n == 0));
      check($sformatf("almostempty%0d", k), 64'(flag_obs[k][2]), 64'(n <= ae_of(k)));
      check($sformatf("full%0d", k), 64'(flag_obs[k][1]), 64'(n == 8));
      check($sformatf("almostfull%0d", k), 64'(flag_obs[k][0]), 64'((8 - n) <= af_of(k)));
    end
  endtask

  task automatic cycle(input bit r, input bit w, input bit rd, input entry_t d);
    RESET = r;
    wren  = w;
    rden  = rd;
    din   = d;
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  function automatic entry_t rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  function automatic entry_t fillv(input int i);
    return {10{8'(i)}};
  endfunction

  initial begin
    m_hp[0] = 1'b0; m_hp[1] = 1'b0;
    m_q[0]  = '0;   m_q[1]  = '0;

    // Reset defaults
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);
    check("rst_q0_zero", 64'(q_obs[0]), 64'd0);
    check("rst_flags0", 64'(flag_obs[0]), 64'b1100);

    // Nibble order: D0=A5, D5=3C
    cycle(0, 1, 0, {32'h0, 8'h3C, 40'hA5});
    cycle(0, 0, 1, '0);
    check("nib_lo_q0", 64'(bus[0].Q0), 64'h5);
    check("nib_lo_q5", 64'(bus[0].Q5), 64'h3C);
    cycle(0, 0, 1, '0);
    check("nib_hi_q0", 64'(bus[0].Q0), 64'hA);
    check("nib_hi_q5", 64'(bus[0].Q5), 64'h3C);
    check("nib_empty", 64'(bus[0].EMPTY), 64'd1);

    // Fill to full, refused 9th write, drain; twice for pointer wrap
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        cycle(0, 1, 0, fillv(i));
        if (i == 6) check("af_after_w7", 64'(bus[0].ALMOSTFULL), 64'd1);
      end
      check("full_after_w8", 64'(bus[0].FULL), 64'd1);
      cycle(0, 1, 0, {80{1'b1}});
      for (int i = 0; i < 16; i++) begin
        cycle(0, 0, 1, '0);
        if (i % 2 == 1) check("drain_order", 64'(bus[0].Q9), 64'(4'((i / 2) >> 4)));
        if (i % 2 == 0) check("drain_lo", 64'(bus[0].Q0), 64'(4'(i / 2)));
      end
    end

    // Full with HP=1, then concurrent write+completing read
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, rnd80());
    cycle(0, 0, 1, '0);
    cycle(0, 1, 1, rnd80());
    check("full_rw_not_full", 64'(bus[0].FULL), 64'd0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, '0);

    // count=3 with completing read plus write
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, rnd80());
    cycle(0, 0, 1, '0);
    cycle(0, 1, 1, rnd80());
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, '0);

    // 4_X_4 almost-empty threshold of 2
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, rnd80());
    check("ae2_after_3w", 64'(bus[1].ALMOSTEMPTY), 64'd0);
    cycle(0, 0, 1, '0);
    check("ae2_after_1r", 64'(bus[1].ALMOSTEMPTY), 64'd1);
    cycle(0, 0, 1, '0);
    cycle(0, 0, 1, '0);

    // Reset mid-read
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, rnd80());
    cycle(0, 1, 0, rnd80());
    cycle(0, 0, 1, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9E});
    cycle(0, 0, 1, '0);
    check("post_rst_lo", 64'(bus[0].Q0), 64'hE);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 60, rnd80());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
